perceptron_seq: RTL and testbench
=================================

# perceptron_seq

Parametrised, sequential perceptron neuron for the MLP datapath. It accepts one (input, coefficient) pair per cycle over a valid/ready stream and accumulates N_INPUTS products plus a bias in a single shared multiply-accumulate unit. It then applies a selectable activation and a saturating output stage, and holds the result on a valid/ready output port. It is the serial, configurable successor to the fully parallel 50-input combinational perceptron, and is intended as the per-neuron building block of multi-neuron layers.

## Interface
- N_INPUTS, 50: pairs per frame; legal range is 2 or more.
- DATA_W, 16: width of input, coefficient and bias; all are two's complement.
- ACC_W, 39: accumulator width; must be at least 2*DATA_W + clog2(N_INPUTS) + 1.
- OUT_W, 33: result width; must be at most ACC_W.
- clk  in  1  the single clock.
- rst_n  in  1  synchronous reset, active-low, sampled on the rising edge of clk.
- in_valid  in  1  a pair is presented.
- in_ready  out  1  the block can accept a pair.
- in_data  in  DATA_W  signed input sample.
- in_coeff  in  DATA_W  signed coefficient.
- bias  in  DATA_W  signed bias; sampled only with the first pair of a frame.
- act_mode  in  2  activation select: 0 = identity, 1 = ReLU, 2 = step, 3 = identity. Sampled only with the first pair of a frame.
- out_valid  out  1  the result is valid.
- out_ready  in  1  the consumer takes the result.
- out_data  out  OUT_W  signed result.
- out_sat  out  1  the result was clipped by saturation; valid while out_valid is high.

## Operation
- An accept is any rising edge with in_valid && in_ready.
- The block has four states: ACCUM, DRAIN, ACT and OUT.
- ACCUM:
  - in_ready = 1.
  - Each accept registers prod_r = in_data * in_coeff as a full 2*DATA_W signed product, sets prod_v = 1, and increments cnt.
  - On the accept with cnt == 0:
    - acc is loaded with bias, sign-extended to ACC_W.
    - act_mode is captured into mode_r.
  - Whenever prod_v = 1 at an edge, acc <= acc + sign-extended prod_r. This is not applied on the cnt == 0 accept, because the pipeline is always empty at that point.
  - The accept with cnt == N_INPUTS-1 clears cnt and moves to DRAIN.
- DRAIN:
  - in_ready = 0.
  - The last product is added and prod_v is cleared.
  - The next state is ACT.
- ACT:
  - in_ready = 0.
  - The activation is applied to acc:
    - identity: pass acc unchanged.
    - ReLU: use 0 if acc < 0, otherwise acc.
    - step: use 1 if acc > 0, otherwise 0.
  - The activated value is saturated to OUT_W signed bounds [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - out_data and out_sat are registered, out_valid is set to 1, and the next state is OUT.
- OUT:
  - in_ready = 0.
  - out_data, out_sat and out_valid are held stable until out_valid && out_ready.
  - On that edge: out_valid = 0, acc = 0, and the next state is ACCUM.
- The accumulator never wraps, because of the ACC_W rule. Saturation occurs only at the output stage.
- in_valid while in_ready = 0 is ignored; its data is not consumed.
- Reset (rst_n = 0 at an edge):
  - state = ACCUM, cnt = 0, acc = 0, prod_r = 0, prod_v = 0, mode_r = 0.
  - Outputs: out_valid = 0, out_data = 0, out_sat = 0.
  - in_ready = 0 during the reset cycle and 1 from the first edge with rst_n = 1.
  - A partial frame, or a result pending in OUT, is discarded.

## Timing
- Multiplier latency is 1 register stage. The add is 1 cycle.
- If the last accept is at edge k:
  - state is DRAIN after edge k;
  - state is ACT after edge k+1;
  - out_valid = 1 after edge k+2.
- With out_ready held at 1, the result is taken at edge k+3 and in_ready = 1 after edge k+3.
- Minimum frame period is N_INPUTS + 3 cycles (53 at defaults).
- Gaps in in_valid within a frame stall the count without corrupting acc. Pending products still drain during gaps.
- in_ready is a function of state only, so there is no combinational path from out_ready to in_ready.
- out_valid does not depend combinationally on out_ready.

## Test plan
- Identity case:
  - Stimulus: bias = 0, mode = 0, pair 0 = (3, 2), pairs 1..49 = (1, 1), pairs streamed back-to-back with out_ready = 1.
  - Response: out_data = 55, out_sat = 0, and out_valid rises 2 cycles after the 50th accept.
- Activation modes:
  - Stimulus: all pairs = (-1, 1), bias = 0.
  - Response: mode 0 gives -50; mode 1 gives 0; mode 2 gives 0.
  - Stimulus: bias = 60 with mode 2.
  - Response: 1.
- Saturation:
  - Stimulus: all pairs = (-32768, -32768), bias = 0, mode 0.
  - Response: out_data = 4294967295 (saturation clips 53687091200), out_sat = 1.
  - Stimulus: the same frame with in_coeff = 32767.
  - Response: out_data = -4294967296, out_sat = 1.
- Backpressure and gaps:
  - Stimulus: in_valid toggled randomly mid-frame, and out_ready held low for 5 cycles after out_valid rises.
  - Response: out_data is stable; in_ready stays 0; exactly one result is transferred; the next frame's bias is re-sampled correctly.
- Reset:
  - Stimulus: rst_n = 0 for 1 cycle after 20 accepts, then a full identity frame as in the first scenario.
  - Response: out_data = 55, with no residue from the aborted frame.
  - Stimulus: reset asserted while in OUT.
  - Response: out_valid = 0 on the next edge.
- Parameter sweep:
  - Stimulus: N_INPUTS = 2, DATA_W = 8, ACC_W = 18, OUT_W = 8 with pairs (100, 100) and (1, 1).
  - Response: out_data = 127, out_sat = 1.

Source files
------------

// File: rtl/perceptron_seq.sv
// perceptron_seq: serial perceptron neuron. One (input, coefficient) pair per
// accepted cycle feeds a single registered multiplier and an accumulator seeded
// with the bias. The result goes through a selectable activation and a
// saturating output stage, then is held on a valid/ready output port.
module perceptron_seq #(
  parameter int N_INPUTS = 50,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 39,
  parameter int OUT_W    = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_coeff,
  input  logic [DATA_W-1:0] bias,
  input  logic [1:0]        act_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(N_INPUTS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_ONE = {{(ACC_W - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_ACCUM = 2'd0,
    S_DRAIN = 2'd1,
    S_ACT   = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       r_rdy_en;
  logic [CNT_W-1:0]           r_cnt;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [PROD_W-1:0]   r_prod;
  logic                       r_prod_v;
  logic [1:0]                 r_mode;
  logic                       r_out_valid;
  logic [OUT_W-1:0]           r_out_data;
  logic                       r_out_sat;

  logic                       w_accept;
  logic                       w_first;
  logic                       w_last;
  logic signed [PROD_W-1:0]   w_a;
  logic signed [PROD_W-1:0]   w_b;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_bias_ext;
  logic signed [ACC_W-1:0]    w_act;
  logic signed [ACC_W-1:0]    w_clip;
  logic                       w_sat;

  assign w_accept   = in_valid && in_ready;
  assign w_first    = (r_cnt == '0);
  assign w_last     = (r_cnt == CNT_LAST);
  assign w_a        = {{DATA_W{in_data[DATA_W-1]}}, in_data};
  assign w_b        = {{DATA_W{in_coeff[DATA_W-1]}}, in_coeff};
  assign w_prod     = w_a * w_b;
  assign w_prod_ext = {{(ACC_W - PROD_W){r_prod[PROD_W-1]}}, r_prod};
  assign w_bias_ext = {{(ACC_W - DATA_W){bias[DATA_W-1]}}, bias};

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_ACCUM;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_ACCUM: if (w_accept && w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_ACT;
      S_ACT:   w_state_nxt = S_OUT;
      S_OUT:   if (r_out_valid && out_ready) w_state_nxt = S_ACCUM;
      default: w_state_nxt = S_ACCUM;
    endcase
  end

  // in_ready depends on registered state only; r_rdy_en holds it low for the reset cycle
  always_comb begin
    in_ready = (r_state == S_ACCUM) && r_rdy_en;
  end

  // Activation followed by clipping to the signed OUT_W range
  always_comb begin
    w_act = r_acc;
    case (r_mode)
      2'd1:    if (r_acc[ACC_W-1]) w_act = '0;
      2'd2:    w_act = (!r_acc[ACC_W-1] && (r_acc != '0)) ? ACC_ONE : '0;
      default: w_act = r_acc;
    endcase
    w_clip = w_act;
    w_sat  = 1'b0;
    if (w_act > SAT_MAX) begin
      w_clip = SAT_MAX;
      w_sat  = 1'b1;
    end else if (w_act < SAT_MIN) begin
      w_clip = SAT_MIN;
      w_sat  = 1'b1;
    end
  end

  // Multiply stage, accumulator, frame counter and output holding registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdy_en    <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_prod      <= '0;
      r_prod_v    <= 1'b0;
      r_mode      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      // a pending product is always consumed at this edge, so prod_v tracks accepts only
      r_prod_v <= w_accept;
      if (w_accept) begin
        r_prod <= w_prod;
        r_cnt  <= w_last ? '0 : r_cnt + CNT_W'(1);
        if (w_first) r_mode <= act_mode;
      end
      if (w_accept && w_first) begin
        r_acc <= w_bias_ext;
      end else if (r_prod_v) begin
        r_acc <= r_acc + w_prod_ext;
      end else if (r_state == S_OUT && r_out_valid && out_ready) begin
        r_acc <= '0;
      end
      if (r_state == S_ACT) begin
        r_out_data  <= w_clip[OUT_W-1:0];
        r_out_sat   <= w_sat;
        r_out_valid <= 1'b1;
      end else if (r_state == S_OUT && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_perceptron_seq.sv
// Bench for perceptron_seq: default-size instance plus a small 2-input instance.
module tb_perceptron_seq;

  localparam int N  = 50;
  localparam int DW = 16;
  localparam int OW = 33;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [DW-1:0] in_data, in_coeff, bias;
  logic [1:0]    act_mode;
  logic [OW-1:0] out_data;

  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_sat;
  logic [7:0]    s_in_data, s_in_coeff, s_bias, s_out_data;
  logic [1:0]    s_act_mode;

  perceptron_seq #(.N_INPUTS(50), .DATA_W(16), .ACC_W(39), .OUT_W(33)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_coeff(in_coeff), .bias(bias), .act_mode(act_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  perceptron_seq #(.N_INPUTS(2), .DATA_W(8), .ACC_W(18), .OUT_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_coeff(s_in_coeff), .bias(s_bias), .act_mode(s_act_mode),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_sat(s_out_sat)
  );

  typedef struct {
    longint data;
    logic   sat;
  } exp_t;

  exp_t sb[$];
  int   pd[N];
  int   pc[N];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference: bias + sum of products, activation, clip to ow-bit signed range
  function automatic exp_t model(input longint b, input int mode, input int n, input int ow);
    exp_t   e;
    longint s, hi, lo;
    s = b;
    for (int i = 0; i < n; i++) s += longint'(pd[i]) * longint'(pc[i]);
    if (mode == 1 && s < 0) s = 0;
    else if (mode == 2) s = (s > 0) ? 1 : 0;
    hi = (longint'(1) << (ow - 1)) - 1;
    lo = -hi - 1;
    e.sat = 1'b0;
    if (s > hi) begin s = hi; e.sat = 1'b1; end
    else if (s < lo) begin s = lo; e.sat = 1'b1; end
    e.data = s;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int d, input int c);
    for (int i = 0; i < N; i++) begin pd[i] = d; pc[i] = c; end
  endtask

  // Streams n pairs from pd/pc; bias/mode are scrambled after the first accept
  task automatic send_frame(input int n, input int b, input int mode, input bit gaps,
                            input bit push);
    int guard;
    bias     = DW'(b);
    act_mode = 2'(mode);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
      end
      in_valid = 1'b1;
      in_data  = DW'(pd[i]);
      in_coeff = DW'(pc[i]);
      guard = 0;
      while (!in_ready && guard < 20) begin step(); guard++; end
      if (!in_ready) begin
        n_total++;
        $display("FAIL in_ready_timeout pair %0d: in_ready=%b required 1", i, in_ready);
      end
      step();
      bias     = DW'($urandom);
      act_mode = 2'($urandom);
    end
    in_valid = 1'b0;
    if (push) sb.push_back(model(longint'(b), mode, n, OW));
  endtask

  task automatic wait_out(output bit ok);
    int guard = 0;
    while (!out_valid && guard < 30) begin step(); guard++; end
    ok = out_valid;
    if (!ok) begin
      n_total++;
      $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_coeff = '0; bias = '0; act_mode = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_in_data = '0; s_in_coeff = '0;
    s_bias = '0; s_act_mode = '0;
    step(); step();
    n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_data !== '0) $display("FAIL rst_out_data: got %0d want 0", out_data); else n_pass++;
    n_total++; if (out_sat !== 1'b0) $display("FAIL rst_out_sat: got %b want 0", out_sat); else n_pass++;
    rst_n = 1'b1;
    step();
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_identity();
    exp_t e;
    fill(1, 1); pd[0] = 3; pc[0] = 2;
    out_ready = 1'b1;
    send_frame(N, 0, 0, 1'b0, 1'b1);
    n_total++; if (in_ready !== 1'b0) $display("FAIL id_drain_ready: got %b want 0", in_ready); else n_pass++;
    step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL id_valid_k1: got %b want 0", out_valid); else n_pass++;
    step();
    n_total++; if (out_valid !== 1'b1) $display("FAIL id_valid_k2: got %b want 1", out_valid); else n_pass++;
    e = sb.pop_front();
    n_total++; if (longint'($signed(out_data)) !== e.data) $display("FAIL id_data: got %0d want %0d", $signed(out_data), e.data); else n_pass++;
    n_total++; if (out_sat !== e.sat) $display("FAIL id_sat: got %b want %b", out_sat, e.sat); else n_pass++;
    step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL id_taken_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL id_taken_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_modes();
    exp_t e;
    bit   ok;
    int   biases[4] = '{0, 0, 0, 60};
    int   modes[4]  = '{0, 1, 2, 2};
    fill(-1, 1);
    for (int k = 0; k < 4; k++) begin
      send_frame(N, biases[k], modes[k], 1'b0, 1'b1);
      wait_out(ok);
      e = sb.pop_front();
      if (ok) begin
        n_total++; if (longint'($signed(out_data)) !== e.data) $display("FAIL mode%0d_b%0d_data: got %0d want %0d", modes[k], biases[k], $signed(out_data), e.data); else n_pass++;
        n_total++; if (out_sat !== e.sat) $display("FAIL mode%0d_b%0d_sat: got %b want %b", modes[k], biases[k], out_sat, e.sat); else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    bit   ok;
    int   coeffs[2] = '{-32768, 32767};
    for (int k = 0; k < 2; k++) begin
      fill(-32768, coeffs[k]);
      send_frame(N, 0, 0, 1'b0, 1'b1);
      wait_out(ok);
      e = sb.pop_front();
      if (ok) begin
        n_total++; if (longint'($signed(out_data)) !== e.data) $display("FAIL sat%0d_data: got %0d want %0d", k, $signed(out_data), e.data); else n_pass++;
        n_total++; if (out_sat !== e.sat) $display("FAIL sat%0d_flag: got %b want %b", k, out_sat, e.sat); else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    exp_t           e;
    bit             ok;
    logic [OW-1:0]  held;
    for (int i = 0; i < N; i++) begin
      pd[i] = int'($urandom_range(0, 400)) - 200;
      pc[i] = int'($urandom_range(0, 400)) - 200;
    end
    out_ready = 1'b0;
    send_frame(N, int'($urandom_range(0, 1000)) - 500, 0, 1'b1, 1'b1);
    wait_out(ok);
    e = sb.pop_front();
    held = out_data;
    n_total++; if (longint'($signed(out_data)) !== e.data) $display("FAIL bp_data: got %0d want %0d", $signed(out_data), e.data); else n_pass++;
    n_total++; if (out_sat !== e.sat) $display("FAIL bp_sat: got %b want %b", out_sat, e.sat); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = 16'h7fff; in_coeff = 16'h7fff; bias = 16'h1234;
      step();
      n_total++; if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0)
        $display("FAIL bp_hold%0d: got v=%b d=%0d r=%b want v=1 d=%0d r=0", c, out_valid, out_data, in_ready, held);
      else n_pass++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    for (int c = 0; c < 3; c++) begin
      n_total++; if (out_valid !== 1'b0) $display("FAIL bp_single%0d: got %b want 0", c, out_valid); else n_pass++;
      step();
    end
    fill(2, 1);
    send_frame(N, -5, 0, 1'b1, 1'b1);
    wait_out(ok);
    e = sb.pop_front();
    if (ok) begin
      n_total++; if (longint'($signed(out_data)) !== e.data) $display("FAIL bp_next_bias: got %0d want %0d", $signed(out_data), e.data); else n_pass++;
    end
    step();
  endtask

  task automatic test_reset_abort();
    exp_t e;
    bit   ok;
    fill(1000, 1000);
    send_frame(20, 99, 1, 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    n_total++; if (in_ready !== 1'b0) $display("FAIL abort_rst_ready: got %b want 0", in_ready); else n_pass++;
    rst_n = 1'b1;
    step();
    fill(1, 1); pd[0] = 3; pc[0] = 2;
    send_frame(N, 0, 0, 1'b0, 1'b1);
    wait_out(ok);
    e = sb.pop_front();
    if (ok) begin
      n_total++; if (longint'($signed(out_data)) !== e.data) $display("FAIL abort_data: got %0d want %0d", $signed(out_data), e.data); else n_pass++;
    end
    step();
    out_ready = 1'b0;
    send_frame(N, 0, 0, 1'b0, 1'b1);
    wait_out(ok);
    void'(sb.pop_front());
    rst_n = 1'b0;
    step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL out_rst_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_data !== '0) $display("FAIL out_rst_data: got %0d want 0", out_data); else n_pass++;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_param_sweep();
    exp_t e;
    int   guard;
    pd[0] = 100; pc[0] = 100; pd[1] = 1; pc[1] = 1;
    s_bias = '0; s_act_mode = '0; s_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_in_valid = 1'b1; s_in_data = 8'(pd[i]); s_in_coeff = 8'(pc[i]);
      guard = 0;
      while (!s_in_ready && guard < 20) begin step(); guard++; end
      step();
    end
    s_in_valid = 1'b0;
    sb.push_back(model(0, 0, 2, 8));
    guard = 0;
    while (!s_out_valid && guard < 20) begin step(); guard++; end
    e = sb.pop_front();
    n_total++; if (longint'($signed(s_out_data)) !== e.data) $display("FAIL sweep_data: got %0d want %0d", $signed(s_out_data), e.data); else n_pass++;
    n_total++; if (s_out_sat !== e.sat) $display("FAIL sweep_sat: got %b want %b", s_out_sat, e.sat); else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_modes();
    test_saturation();
    test_backpressure();
    test_reset_abort();
    test_param_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
